// File: rtl/conv_result_fifo.sv
// Memory-mapped result buffer between the convolution accelerator stream and the CPU EXT bus.
// Captures pushed result words in a FIFO; the CPU pops them through a one-cycle registered read port.
module conv_result_fifo #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned AWIDTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              bus_en,
   input  logic              bus_we,
   input  logic [AWIDTH-1:0] bus_addr,
   input  logic [DATA_W-1:0] bus_din,
   output logic [DATA_W-1:0] bus_dout,
   output logic              irq
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned TW = 8;
   localparam int unsigned IW = (CW > TW) ? CW : TW;

   localparam logic [AWIDTH-1:0] A_DATA   = AWIDTH'(0);
   localparam logic [AWIDTH-1:0] A_STATUS = AWIDTH'(1);
   localparam logic [AWIDTH-1:0] A_CTRL   = AWIDTH'(2);
   localparam logic [AWIDTH-1:0] A_THRESH = AWIDTH'(3);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [CW-1:0]     wr_ptr;
   logic [CW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              cap_en;
   logic              ovf;
   logic              udf;
   logic [TW-1:0]     thresh;

   logic              empty;
   logic              full;
   logic              rd_stb;
   logic              wr_stb;
   logic              push;
   logic              pop;
   logic              flush;
   logic              flag_clr;
   logic              ctrl_wr;
   logic              thr_wr;
   logic              ovf_set;
   logic              udf_set;
   logic [DATA_W-1:0] rd_data;
   logic              din_unused;

   // Extra pointer MSB distinguishes full from empty; count wraps naturally.
   assign count    = wr_ptr - rd_ptr;
   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign in_ready = cap_en & ~full;
   assign irq      = (thresh != '0) && (IW'(count) >= IW'(thresh));

   assign rd_stb   = bus_en & ~bus_we;
   assign wr_stb   = bus_en & bus_we;
   assign push     = in_valid & in_ready;
   assign pop      = rd_stb & (bus_addr == A_DATA) & ~empty;
   assign udf_set  = rd_stb & (bus_addr == A_DATA) & empty;
   assign ovf_set  = cap_en & in_valid & full;
   assign ctrl_wr  = wr_stb & (bus_addr == A_CTRL);
   assign thr_wr   = wr_stb & (bus_addr == A_THRESH);
   assign flush    = ctrl_wr & bus_din[0];
   assign flag_clr = ctrl_wr & bus_din[1];

   assign din_unused = ^bus_din[DATA_W-1:TW];

   // Register read mux; an empty DATA read returns zero.
   always_comb begin
      rd_data = '0;
      case (bus_addr)
         A_DATA:   if (!empty) rd_data = mem[rd_ptr[PW-1:0]];
         A_STATUS: rd_data = DATA_W'({8'(count), 3'b000, cap_en, udf, ovf, full, empty});
         A_CTRL:   rd_data = DATA_W'({cap_en, 2'b00});
         A_THRESH: rd_data = DATA_W'(thresh);
         default:  rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PW-1:0]] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cap_en   <= 1'b0;
         thresh   <= '0;
         ovf      <= 1'b0;
         udf      <= 1'b0;
         bus_dout <= '0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + CW'(1);
            if (pop)  rd_ptr <= rd_ptr + CW'(1);
         end
         if (ctrl_wr) cap_en <= bus_din[2];
         if (thr_wr)  thresh <= bus_din[TW-1:0];
         // A new event in the same cycle as a clear keeps the flag set.
         if (ovf_set)       ovf <= 1'b1;
         else if (flag_clr) ovf <= 1'b0;
         if (udf_set)       udf <= 1'b1;
         else if (flag_clr) udf <= 1'b0;
         if (rd_stb) bus_dout <= rd_data;
      end
   end

endmodule
